imm_extend_pipe: RTL and testbench

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 128 ++++++++++++
 tb/tb_imm_extend_pipe.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a 2-entry FIFO; extension is computed at push time and stored.
// Optional build macro IMM_EXT_UPPER_EN enables upper placement for mode 2 (otherwise mode 2 sign-extends).
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       occupancy
);

    localparam int EXT_W = OUT_W - IN_W;
    localparam int DEPTH = 2;

    typedef enum logic [1:0] {
        MODE_SIGN   = 2'd0,
        MODE_ZERO   = 2'd1,
        MODE_UPPER  = 2'd2,
        MODE_BRANCH = 2'd3
    } ext_mode_t;

    logic [OUT_W-1:0] sign_ext;
    logic [OUT_W-1:0] zero_ext;
    logic [OUT_W-1:0] branch_ext;
    logic [OUT_W-1:0] ext_value;

    logic [1:0]       occ_reg;
    logic [1:0]       occ_next;
    logic             wr_ptr_reg;
    logic             wr_ptr_next;
    logic             rd_ptr_reg;
    logic             rd_ptr_next;
    logic             push;
    logic             pop;
    logic             write_en;
    logic [OUT_W-1:0] entry_data [DEPTH];

    assign sign_ext   = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    assign zero_ext   = {{EXT_W{1'b0}}, in_imm};
    assign branch_ext = {sign_ext[OUT_W-3:0], 2'b00};

    always_comb begin
        ext_value = sign_ext;
        case (ext_mode_t'(in_mode))
            MODE_SIGN:   ext_value = sign_ext;
            MODE_ZERO:   ext_value = zero_ext;
`ifdef IMM_EXT_UPPER_EN
            MODE_UPPER:  ext_value = {in_imm, {EXT_W{1'b0}}};
`else
            MODE_UPPER:  ext_value = sign_ext;
`endif
            MODE_BRANCH: ext_value = branch_ext;
            default:     ext_value = sign_ext;
        endcase
    end

    // Handshakes depend only on registered occupancy, so in_ready never looks at out_ready.
    assign in_ready  = (occ_reg < 2'(DEPTH));
    assign out_valid = (occ_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign write_en  = push && !flush;
    assign occupancy = occ_reg;

    always_comb begin
        occ_next    = occ_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (flush) begin
            occ_next    = 2'd0;
            wr_ptr_next = 1'b0;
            rd_ptr_next = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   occ_next = occ_reg + 2'd1;
                2'b01:   occ_next = occ_reg - 2'd1;
                default: occ_next = occ_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            occ_reg    <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            occ_reg    <= occ_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
            logic [OUT_W-1:0] entry_reg;

            always_ff @(posedge clk or negedge rstb) begin
                if (!rstb) begin
                    entry_reg <= '0;
                end else if (write_en && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= ext_value;
                end
            end

            assign entry_data[gi] = entry_reg;
        end
    endgenerate

    // Gating by out_valid makes out_data read zero whenever the buffer is empty, including in reset.
    assign out_data = out_valid ? entry_data[rd_ptr_reg] : '0;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised + directed bench for imm_extend_pipe against a queue-based reference model.
// Build with +define+IMM_EXT_UPPER_EN to exercise upper placement in mode 2.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rstb;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [31:0] model_q[$];

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference extension computed arithmetically from the immediate's signed value.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] md);
        int s;
        s = (imm >= 16'h8000) ? (int'(imm) - 65536) : int'(imm);
        case (md)
            2'd1:    return 32'(int'(imm));
`ifdef IMM_EXT_UPPER_EN
            2'd2:    return 32'(int'(imm) * 65536);
`else
            2'd2:    return 32'(s);
`endif
            2'd3:    return 32'(s * 4);
            default: return 32'(s);
        endcase
    endfunction

    task automatic compare_model(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".occ"},   32'(occupancy), 32'(n));
        check({tag, ".ovld"},  32'(out_valid), 32'(n != 0));
        check({tag, ".irdy"},  32'(in_ready),  32'(n < 2));
        check({tag, ".odata"}, out_data, (n != 0) ? model_q[0] : 32'h0);
    endtask

    // Called at a negedge: drive, compare, apply one rising edge to the model, return at next negedge.
    task automatic cycle(input string tag, input logic iv, input logic [15:0] imm,
                         input logic [1:0] md, input logic ordy, input logic fl);
        bit do_push;
        bit do_pop;
        in_valid  = iv;
        in_imm    = imm;
        in_mode   = md;
        out_ready = ordy;
        flush     = fl;
        #1;
        compare_model(tag);
        do_push = iv && (model_q.size() < 2);
        do_pop  = ordy && (model_q.size() > 0);
        if (do_push || do_pop || fl)
            $display("txn %s push=%0d imm=%h mode=%0d pop=%0d flush=%0d occ=%0d",
                     tag, do_push, imm, md, do_pop, fl, model_q.size());
        @(posedge clk);
        if (fl) model_q.delete();
        else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(ref_ext(imm, md));
        end
        @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; out_ready = 1'b0;
        #3;
        check("rst.irdy", 32'(in_ready), 32'd1);
        check("rst.ovld", 32'(out_valid), 32'd0);
        check("rst.occ",  32'(occupancy), 32'd0);
        check("rst.data", out_data, 32'h0);
        @(negedge clk); @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        // Mode 0 back-to-back, one cycle latency each
        cycle("m0a", 1, 16'hFFFF, 2'd0, 1, 0);
        check("m0a.val", out_data, 32'hFFFFFFFF);
        cycle("m0b", 1, 16'h0001, 2'd0, 1, 0);
        check("m0b.val", out_data, 32'h00000001);
        cycle("drain", 0, 16'h0, 2'd0, 1, 0);
        cycle("underflow", 0, 16'h0, 2'd0, 1, 0);
        check("underflow.occ", 32'(occupancy), 32'd0);

        // Modes 1/2/3 with 0x8004
        cycle("m1", 1, 16'h8004, 2'd1, 1, 0);
        check("m1.val", out_data, 32'h00008004);
        cycle("m2", 1, 16'h8004, 2'd2, 1, 0);
`ifdef IMM_EXT_UPPER_EN
        check("m2.val", out_data, 32'h80040000);
`else
        check("m2.val", out_data, 32'hFFFF8004);
`endif
        cycle("m3", 1, 16'h8004, 2'd3, 1, 0);
        check("m3.val", out_data, 32'hFFFE0010);
        cycle("drain", 0, 16'h0, 2'd0, 1, 0);

        // Backpressure: third push refused, then ordered drain
        cycle("bp3", 1, 16'h0003, 2'd0, 0, 0);
        cycle("bp4", 1, 16'h0004, 2'd0, 0, 0);
        check("bp.full.occ",  32'(occupancy), 32'd2);
        check("bp.full.irdy", 32'(in_ready), 32'd0);
        cycle("bp5", 1, 16'h0005, 2'd0, 0, 0);
        check("bp.hold.data", out_data, 32'h00000003);
        cycle("bp.pop3", 0, 16'h0, 2'd0, 1, 0);
        check("bp.pop.irdy", 32'(in_ready), 32'd1);
        check("bp.pop.data", out_data, 32'h00000004);
        cycle("bp.pop4", 0, 16'h0, 2'd0, 1, 0);
        check("bp.empty.occ", 32'(occupancy), 32'd0);

        // Simultaneous push/pop at occupancy 1
        cycle("pp.fill", 1, 16'h0006, 2'd0, 0, 0);
        cycle("pp", 1, 16'h0007, 2'd0, 1, 0);
        check("pp.occ",  32'(occupancy), 32'd1);
        check("pp.data", out_data, 32'h00000007);

        // Flush at full with in_valid high
        cycle("fl.fill", 1, 16'h0008, 2'd0, 0, 0);
        cycle("fl", 1, 16'h0009, 2'd0, 1, 1);
        check("fl.occ",  32'(occupancy), 32'd0);
        check("fl.ovld", 32'(out_valid), 32'd0);
        check("fl.irdy", 32'(in_ready), 32'd1);

        // Asynchronous reset between edges with occupancy 2
        cycle("ar.a", 1, 16'h00AA, 2'd0, 0, 0);
        cycle("ar.b", 1, 16'h00BB, 2'd0, 0, 0);
        check("ar.pre.occ", 32'(occupancy), 32'd2);
        #2 rstb = 1'b0;
        #1;
        check("ar.occ",  32'(occupancy), 32'd0);
        check("ar.ovld", 32'(out_valid), 32'd0);
        check("ar.data", out_data, 32'h0);
        check("ar.irdy", 32'(in_ready), 32'd1);
        model_q.delete();
        @(negedge clk);
        rstb = 1'b1;
        cycle("ar.post", 1, 16'h0011, 2'd1, 0, 0);
        check("ar.first", out_data, 32'h00000011);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
